// File: rtl/circle_encoder.sv
// Encodes a target point as two packed circle words {x, y, r}, one per anchor,
// for the circle-intersection solver. The radii come from a shared bit-serial square root.
module circle_encoder #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] target,
  input  logic [2*N-1:0] anchorB,
  input  logic [2*N-1:0] anchorC,
  output logic [3*N:0]   g_output,
  output logic [3*N:0]   e_output,
  output logic           busy,
  output logic           done,
  output logic [1:0]     sat
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_ROOT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [N:0] R_MAX = {1'b0, {N{1'b1}}};

  logic [1:0]     state;
  logic [2*N-1:0] tgt_q;
  logic [2*N-1:0] b_q;
  logic [2*N-1:0] c_q;
  logic [2*N+1:0] d2b_q;
  logic [2*N+1:0] d2c_q;
  logic [N:0]     rootb_q;
  logic [N:0]     rootc_q;
  logic [CW-1:0]  cnt_q;

  // Squared Euclidean distance between two packed {x, y} points. Both
  // differences fit in N+1 signed bits, so the sum is exact in 2N+2 bits.
  function automatic logic [2*N+1:0] dist2(input logic [2*N-1:0] a,
                                           input logic [2*N-1:0] t);
    logic signed [N:0]     dx;
    logic signed [N:0]     dy;
    logic signed [2*N+1:0] sx;
    logic signed [2*N+1:0] sy;
    dx = signed'({a[2*N-1], a[2*N-1:N]}) - signed'({t[2*N-1], t[2*N-1:N]});
    dy = signed'({a[N-1], a[N-1:0]}) - signed'({t[N-1], t[N-1:0]});
    sx = (2*N+2)'(dx) * (2*N+2)'(dx);
    sy = (2*N+2)'(dy) * (2*N+2)'(dy);
    return unsigned'(sx + sy);
  endfunction

  // One restoring square-root step: keep bit_idx if the trial still squares under d2.
  function automatic logic [N:0] root_step(input logic [N:0]     root,
                                           input logic [2*N+1:0] d2,
                                           input logic [CW-1:0]  bit_idx);
    logic [N:0]     one;
    logic [N:0]     trial;
    logic [2*N+1:0] trial_sq;
    one      = (N+1)'(1);
    trial    = root | (one << bit_idx);
    trial_sq = {(N+1)'(0), trial} * {(N+1)'(0), trial};
    return (trial_sq <= d2) ? trial : root;
  endfunction

  // The solver reads r as signed N+1 bits, so anything above 2^N-1 is pinned there.
  function automatic logic [N:0] clamp(input logic [N:0] root);
    return root[N] ? R_MAX : root;
  endfunction

  // NOTE: every register here, including the wide datapath ones, is cleared on
  // reset so an aborted computation leaves no trace in later results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      tgt_q    <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d2b_q    <= '0;
      d2c_q    <= '0;
      rootb_q  <= '0;
      rootc_q  <= '0;
      cnt_q    <= '0;
      g_output <= '0;
      e_output <= '0;
      sat      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt_q <= target;
            b_q   <= anchorB;
            c_q   <= anchorC;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          d2b_q   <= dist2(b_q, tgt_q);
          d2c_q   <= dist2(c_q, tgt_q);
          rootb_q <= '0;
          rootc_q <= '0;
          cnt_q   <= CW'(N);
          state   <= S_ROOT;
        end
        S_ROOT: begin
          rootb_q <= root_step(rootb_q, d2b_q, cnt_q);
          rootc_q <= root_step(rootc_q, d2c_q, cnt_q);
          if (cnt_q == '0) begin
            state <= S_OUT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_OUT: begin
          g_output <= {b_q, clamp(rootb_q)};
          e_output <= {c_q, clamp(rootc_q)};
          sat      <= {rootb_q[N], rootc_q[N]};
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_encoder.sv
// Directed and random checks of circle_encoder (N=8) against an integer
// distance / square-root reference model.
module tb_circle_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target;
  logic [15:0] anchorB;
  logic [15:0] anchorC;
  logic [24:0] g_output;
  logic [24:0] e_output;
  logic        busy;
  logic        done;
  logic [1:0]  sat;

  int n_cmp  = 0;
  int n_fail = 0;

  circle_encoder #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .anchorB  (anchorB),
    .anchorC  (anchorC),
    .g_output (g_output),
    .e_output (e_output),
    .busy     (busy),
    .done     (done),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Circle word for one anchor: the anchor echoed, radius = min(floor(sqrt(d^2)), 255).
  function automatic void model(input logic [15:0] t, input logic [15:0] a,
                                output logic [24:0] word, output logic s);
    int dx = sx8(a[15:8]) - sx8(t[15:8]);
    int dy = sx8(a[7:0]) - sx8(t[7:0]);
    int r  = isqrt(dx * dx + dy * dy);
    s = (r > 255);
    if (s) r = 255;
    word = {a, 9'(r)};
  endfunction

  // Pulse start with the given inputs and wait (bounded) for done.
  // lat counts cycles from the accept edge; held reports outputs stayed frozen meanwhile.
  task automatic run(input logic [15:0] t, input logic [15:0] b, input logic [15:0] c,
                     output int lat, output logic held);
    logic [24:0] g_prev;
    @(negedge clk);
    target = t; anchorB = b; anchorC = c; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    g_prev = g_output;
    held   = 1'b1;
    lat    = 0;
    while (!done && lat < 40) begin
      if (g_output !== g_prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [15:0] t,
                               input logic [15:0] b, input logic [15:0] c);
    logic [24:0] gw, ew;
    logic        sb, sc;
    model(t, b, gw, sb);
    model(t, c, ew, sc);
    check({tag, "_g"}, 32'(g_output), 32'(gw));
    check({tag, "_e"}, 32'(e_output), 32'(ew));
    check({tag, "_sat"}, 32'(sat), 32'({sb, sc}));
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic        held;
    logic [15:0] t, b, c;

    rst = 1'b0; start = 1'b0; target = '0; anchorB = '0; anchorC = '0;
    repeat (2) @(negedge clk);
    check("rst_g", 32'(g_output), 32'h0);
    check("rst_e", 32'(e_output), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sat", 32'(sat), 32'h0);
    rst = 1'b1;

    // Pythagorean anchors: radii 5 and 10.
    run(16'h0000, 16'h0304, 16'hFA08, lat, held);
    check("pyth_lat", 32'(lat), 32'd11);
    check("pyth_busy_low", 32'(busy), 32'h0);
    check("pyth_g_const", 32'(g_output), 32'h060805);
    check("pyth_rc", 32'(e_output[8:0]), 32'd10);
    check("pyth_e_const", 32'(e_output), {7'd0, 8'hFA, 8'h08, 9'd10});
    check("pyth_sat", 32'(sat), 32'h0);
    check("pyth_held", 32'(held), 32'h1);
    @(negedge clk);
    check("pyth_done_pulse", 32'(done), 32'h0);

    // Non-square distance and zero distance.
    run(16'h0101, 16'h0403, 16'h0101, lat, held);
    check("nsq_lat", 32'(lat), 32'd11);
    check("nsq_rb", 32'(g_output[8:0]), 32'd3);
    check("nsq_rc", 32'(e_output[8:0]), 32'd0);
    expect_result("nsq", 16'h0101, 16'h0403, 16'h0101);

    // Negative y echoed unchanged.
    run(16'h0101, 16'h0403, 16'h05F0, lat, held);
    expect_result("negy", 16'h0101, 16'h0403, 16'h05F0);

    // Clamp boundary: 255 is exact, 127,127 overflows.
    run(16'h8000, 16'h7F00, 16'h7F7F, lat, held);
    check("clamp_rb", 32'(g_output[8:0]), 32'd255);
    check("clamp_rc", 32'(e_output[8:0]), 32'd255);
    check("clamp_sat", 32'(sat), 32'b01);

    // Back-to-back: ignored start mid-run, then start on the done cycle.
    @(negedge clk);
    target = 16'h0000; anchorB = 16'h0304; anchorC = 16'h0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    target = 16'h1020; anchorB = 16'hE0F0; anchorC = 16'h4444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 6;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_first_lat", 32'(cnt), 32'd11);
    expect_result("b2b_first", 16'h0000, 16'h0304, 16'h0600);
    target = 16'hF00A; anchorB = 16'h3C9C; anchorC = 16'h8181; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_gap", 32'(cnt), 32'd12);
    expect_result("b2b_second", 16'hF00A, 16'h3C9C, 16'h8181);

    // Reset during ROOT aborts the computation silently.
    @(negedge clk);
    target = 16'h0102; anchorB = 16'h3344; anchorC = 16'hC0D0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_g", 32'(g_output), 32'h0);
    check("mid_rst_e", 32'(e_output), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_sat", 32'(sat), 32'h0);
    cnt = 0;
    repeat (14) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 32'(cnt), 32'h0);
    run(16'h0102, 16'h3344, 16'hC0D0, lat, held);
    check("post_rst_lat", 32'(lat), 32'd11);
    expect_result("post_rst", 16'h0102, 16'h3344, 16'hC0D0);

    // Random regression, with occasional extreme corners.
    for (int i = 0; i < 300; i++) begin
      t = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      if (i % 10 == 0) b = t;
      if (i % 7 == 0) begin
        t = {$urandom_range(0, 1) ? 8'h80 : 8'h7F, $urandom_range(0, 1) ? 8'h80 : 8'h7F};
        c = ~t;
      end
      run(t, b, c, lat, held);
      check("rnd_lat", 32'(lat), 32'd11);
      check("rnd_held", 32'(held), 32'h1);
      expect_result("rnd", t, b, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
